// File: rtl/dev_i2c_pkg.sv
// Shared constants for the dev_i2c target PHY: FSM states, ACK levels, bit-counter width.
// Optional build macro used by this slice: DEV_I2C_SLV_STRETCH_EN.
package dev_i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_A_ACK,
    ST_WR,
    ST_W_ACK,
    ST_RD_LD,
    ST_RD,
    ST_M_ACK,
    ST_WAIT
  } state_t;

  localparam logic ACK_LVL  = 1'b0;
  localparam logic NACK_LVL = 1'b1;

  localparam int unsigned BIT_CNT_W = 3;

endpackage

// File: rtl/dev_i2c_slv_filter.sv
// Pin conditioner: 2-flop synchroniser, FILTER_LEN-sample glitch filter, rise/fall pulses.
// Edge pulses are asserted 2+FILTER_LEN clk after the pin changes.
module dev_i2c_slv_filter
  import dev_i2c_pkg::*;
#(
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [1:0]            sync;
  logic [FILTER_LEN-1:0] hist;

  // Level flips only once the whole history window agrees with the new value.
  assign rise = (&hist) & ~level;
  assign fall = ~(|hist) & level;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync  <= '1;
      hist  <= '1;
      level <= 1'b1;
    end else begin
      sync <= {sync[0], pin};
      hist <= (hist << 1) | FILTER_LEN'(sync[1]);
      if (rise)      level <= 1'b1;
      else if (fall) level <= 1'b0;
    end
  end

endmodule

// File: rtl/dev_i2c_slv_phy.sv
// I2C target PHY: START/STOP detection, address match/ACK, write delivery, read serialisation.
// Define DEV_I2C_SLV_STRETCH_EN to hold SCL low while waiting for read data (no underrun).
module dev_i2c_slv_phy
  import dev_i2c_pkg::*;
#(
  parameter int unsigned FILTER_LEN = 3,
  parameter int unsigned ADDR_W     = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_en,
  input  logic [ADDR_W-1:0] cfg_addr,
  output logic              o_start,
  output logic              o_stop,
  output logic              o_sel,
  output logic              o_rw,
  output logic              o_val,
  output logic [7:0]        o_data,
  output logic              o_rd_req,
  input  logic              i_stb,
  input  logic [7:0]        i_data,
  output logic              o_nack,
  output logic              o_err,
  inout  wire               i2c_sda,
  inout  wire               i2c_scl
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  dev_i2c_slv_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
    .clk(clk), .rst(rst), .pin(i2c_scl), .level(scl_lvl), .rise(scl_rise), .fall(scl_fall)
  );

  dev_i2c_slv_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
    .clk(clk), .rst(rst), .pin(i2c_sda), .level(sda_lvl), .rise(sda_rise), .fall(sda_fall)
  );

  state_t               state;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [7:0]           shreg;
  logic                 sda_oe, scl_oe;
  logic                 ack_on, loaded, fall_seen;
  logic                 start_ev, stop_ev;

  assign start_ev = sda_fall & scl_lvl;
  assign stop_ev  = sda_rise & scl_lvl;

  assign i2c_sda = sda_oe ? 1'b0 : 1'bz;
  assign i2c_scl = scl_oe ? 1'b0 : 1'bz;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      sda_oe    <= 1'b0;
      scl_oe    <= 1'b0;
      ack_on    <= 1'b0;
      loaded    <= 1'b0;
      fall_seen <= 1'b0;
      o_start   <= 1'b0;
      o_stop    <= 1'b0;
      o_sel     <= 1'b0;
      o_rw      <= 1'b0;
      o_val     <= 1'b0;
      o_data    <= '0;
      o_rd_req  <= 1'b0;
      o_nack    <= 1'b0;
      o_err     <= 1'b0;
    end else begin
      o_start  <= 1'b0;
      o_stop   <= 1'b0;
      o_val    <= 1'b0;
      o_rd_req <= 1'b0;
      o_nack   <= 1'b0;
      o_err    <= 1'b0;
      if (start_ev) begin
        state   <= ST_ADDR;
        bit_cnt <= '0;
        o_start <= 1'b1;
        o_sel   <= 1'b0;
        sda_oe  <= 1'b0;
        scl_oe  <= 1'b0;
        ack_on  <= 1'b0;
      end else if (stop_ev) begin
        state  <= ST_IDLE;
        o_stop <= 1'b1;
        o_sel  <= 1'b0;
        sda_oe <= 1'b0;
        scl_oe <= 1'b0;
        ack_on <= 1'b0;
      end else begin
        case (state)
          ST_ADDR: if (scl_rise) begin
            shreg   <= {shreg[6:0], sda_lvl};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == '1) begin
              o_rw <= sda_lvl;
              if (cfg_en && shreg[ADDR_W-1:0] == cfg_addr) begin
                state  <= ST_A_ACK;
                o_sel  <= 1'b1;
                ack_on <= 1'b0;
              end else begin
                state <= ST_WAIT;
              end
            end
          end
          // For reads the data request is raised at the ACK-slot rise so the
          // local side has half an SCL period before bit 7 is due.
          ST_A_ACK: begin
            if (scl_fall) begin
              if (!ack_on) begin
                sda_oe <= 1'b1;
                ack_on <= 1'b1;
              end else if (!o_rw) begin
                sda_oe  <= 1'b0;
                ack_on  <= 1'b0;
                bit_cnt <= '0;
                state   <= ST_WR;
              end
            end else if (scl_rise && ack_on && o_rw) begin
              state     <= ST_RD_LD;
              o_rd_req  <= 1'b1;
              ack_on    <= 1'b0;
              loaded    <= 1'b0;
              fall_seen <= 1'b0;
            end
          end
          ST_WR: if (scl_rise) begin
            shreg   <= {shreg[6:0], sda_lvl};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == '1) begin
              o_data <= {shreg[6:0], sda_lvl};
              o_val  <= 1'b1;
              ack_on <= 1'b0;
              state  <= ST_W_ACK;
            end
          end
          ST_W_ACK: begin
            if (scl_oe) scl_oe <= 1'b0;
            if (scl_fall) begin
              if (!ack_on) begin
                sda_oe <= 1'b1;
                ack_on <= 1'b1;
`ifdef DEV_I2C_SLV_STRETCH_EN
                scl_oe <= 1'b1;
`endif
              end else begin
                sda_oe  <= 1'b0;
                ack_on  <= 1'b0;
                bit_cnt <= '0;
                state   <= ST_WR;
              end
            end
          end
          // A strobe coinciding with the bit-7 fall wins; the bit goes out next clk.
          ST_RD_LD: begin
            if (i_stb && !loaded) begin
              shreg  <= i_data;
              loaded <= 1'b1;
              if (scl_fall) begin
                fall_seen <= 1'b1;
                sda_oe    <= 1'b0;
              end
            end else if (scl_fall || fall_seen) begin
              if (loaded) begin
                sda_oe  <= ~shreg[7];
                scl_oe  <= 1'b0;
                bit_cnt <= '0;
                state   <= ST_RD;
              end else begin
`ifdef DEV_I2C_SLV_STRETCH_EN
                scl_oe    <= 1'b1;
                sda_oe    <= 1'b0;
                fall_seen <= 1'b1;
`else
                shreg   <= '1;
                sda_oe  <= 1'b0;
                o_err   <= 1'b1;
                bit_cnt <= '0;
                state   <= ST_RD;
`endif
              end
            end
          end
          ST_RD: if (scl_fall) begin
            shreg   <= shreg << 1;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == '1) begin
              sda_oe <= 1'b0;
              state  <= ST_M_ACK;
            end else begin
              sda_oe <= ~shreg[6];
            end
          end
          ST_M_ACK: if (scl_rise) begin
            if (sda_lvl == ACK_LVL) begin
              state     <= ST_RD_LD;
              o_rd_req  <= 1'b1;
              loaded    <= 1'b0;
              fall_seen <= 1'b0;
            end else begin
              o_nack <= 1'b1;
              state  <= ST_WAIT;
            end
          end
          default: begin
            sda_oe <= 1'b0;
            scl_oe <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
